icache_ctrl: RTL and testbench

- Direct-mapped, read-only instruction cache that consumes the core's icache request/response interface (idx, op, pa, is_cached, stall, busy, data, data_valid).
- On a cached miss it refills a full line over a simple burst-read memory port. Uncached fetches issue a single-word read.
- Also executes index- and hit-invalidate cache ops.
- Sits between the fetch stages and the memory bridge.

---
 rtl/icache_ctrl_if.sv | 36 +++
 rtl/icache_ctrl.sv | 177 +++++++++++++++++
 tb/tb_icache_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Core fetch request/response signals plus the burst-read memory port of the icache.
interface icache_ctrl_if;
  // Core side
  logic        stall_icache;
  logic [11:0] icache_idx;
  logic [2:0]  icache_op;
  logic        icache_is_cached;
  logic [31:0] icache_pa;
  logic [31:0] icache_data;
  logic        icache_data_valid;
  logic        icache_busy;
  // Memory side
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic [7:0]  mem_rd_len;
  logic        mem_rd_rdy;
  logic        mem_ret_valid;
  logic        mem_ret_last;
  logic [31:0] mem_ret_data;

  // Cache controller view
  modport slave (
    input  stall_icache, icache_idx, icache_op, icache_is_cached, icache_pa,
    input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    output icache_data, icache_data_valid, icache_busy,
    output mem_rd_req, mem_rd_addr, mem_rd_len
  );

  // Fetch stage and memory bridge view
  modport master (
    output stall_icache, icache_idx, icache_op, icache_is_cached, icache_pa,
    output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    input  icache_data, icache_data_valid, icache_busy,
    input  mem_rd_req, mem_rd_addr, mem_rd_len
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, line refill on cached miss,
// single-word reads for uncached fetches, index/hit invalidate ops.
module icache_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 256,
  parameter int unsigned TAG_W      = 20
) (
  input logic          clk,
  input logic          rst,
  icache_ctrl_if.slave bus_io
);
  localparam int unsigned WordW  = $clog2(LINE_WORDS);
  localparam int unsigned SetW   = $clog2(SETS);
  localparam int unsigned SetLsb = WordW + 2;

  localparam logic [2:0] OpRead   = 3'd1;
  localparam logic [2:0] OpIdxInv = 3'd2;
  localparam logic [2:0] OpHitInv = 3'd3;

  typedef enum logic [2:0] {StIdle, StMissReq, StRefill, StUncReq, StUncWait, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid_q, valid_d;

  // Stage-2 request and registered array read
  logic             s2_valid_q, s2_valid_d;
  logic [2:0]       op_q;
  logic [11:0]      idx_q;
  logic [31:0]      pa_q;
  logic             cached_q;
  logic [TAG_W-1:0] rd_tag_q;
  logic [31:0]      rd_data_q;

  logic [WordW-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_word_q, rsp_word_d;

  logic             req_op, accept, busy, tag_hit, s2_read, s2_hit, s2_fill, fill_beat;
  logic [SetW-1:0]  s2_set;
  logic [WordW-1:0] s2_word;
  logic [TAG_W-1:0] s2_tag;
  logic             unused_bits;

  assign req_op    = bus_io.icache_op inside {OpRead, OpIdxInv, OpHitInv};
  assign accept    = req_op && !busy && !bus_io.stall_icache;
  assign s2_set    = idx_q[SetLsb +: SetW];
  assign s2_word   = idx_q[2 +: WordW];
  assign s2_tag    = pa_q[31 -: TAG_W];
  assign tag_hit   = valid_q[s2_set] && (rd_tag_q == s2_tag);
  assign s2_read   = s2_valid_q && (op_q == OpRead);
  assign s2_hit    = s2_read && cached_q && tag_hit;
  // Uncached reads always go to memory, even when the tag happens to match.
  assign s2_fill   = s2_read && !(cached_q && tag_hit);
  assign fill_beat = (state_q == StRefill) && bus_io.mem_ret_valid;
  // Busy already in the miss-detect cycle so nothing is accepted behind a miss.
  assign busy      = (state_q != StIdle) || s2_fill;

  assign unused_bits = ^{idx_q[1:0], pa_q[1:0]};

  // Stage 2 loads on accept, holds while stalled, and is consumed once a fill starts.
  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_fill) begin
      s2_valid_d = 1'b0;
    end else if (!bus_io.stall_icache) begin
      s2_valid_d = accept;
    end
  end

  // Control state, valid bits, request latch and array read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      s2_valid_q <= 1'b0;
      op_q       <= '0;
      idx_q      <= '0;
      pa_q       <= '0;
      cached_q   <= 1'b0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      rsp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      rsp_word_q <= rsp_word_d;
      if (accept) begin
        op_q      <= bus_io.icache_op;
        idx_q     <= bus_io.icache_idx;
        pa_q      <= bus_io.icache_pa;
        cached_q  <= bus_io.icache_is_cached;
        rd_tag_q  <= tag_mem[bus_io.icache_idx[SetLsb +: SetW]];
        rd_data_q <= data_mem[bus_io.icache_idx[2 +: SetW+WordW]];
      end
    end
  end

  // Refill writes into the tag/data arrays; the arrays themselves are not reset.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_mem[{s2_set, cnt_q}] <= bus_io.mem_ret_data;
      if (bus_io.mem_ret_last) begin
        tag_mem[s2_set] <= s2_tag;
      end
    end
  end

  // Next-state logic: invalidations, miss/uncached sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    rsp_word_d = rsp_word_q;
    case (state_q)
      StIdle: begin
        if (s2_valid_q && (op_q == OpIdxInv)) valid_d[s2_set] = 1'b0;
        if (s2_valid_q && (op_q == OpHitInv) && tag_hit) valid_d[s2_set] = 1'b0;
        if (s2_fill) state_d = cached_q ? StMissReq : StUncReq;
      end
      StMissReq: begin
        cnt_d = '0;
        if (bus_io.mem_rd_rdy) state_d = StRefill;
      end
      StRefill: begin
        if (bus_io.mem_ret_valid) begin
          cnt_d = cnt_q + WordW'(1);
          if (cnt_q == s2_word) rsp_word_d = bus_io.mem_ret_data;
          // A short burst still marks the line valid.
          if (bus_io.mem_ret_last) begin
            valid_d[s2_set] = 1'b1;
            state_d         = StResp;
          end
        end
      end
      StUncReq: begin
        if (bus_io.mem_rd_rdy) state_d = StUncWait;
      end
      StUncWait: begin
        if (bus_io.mem_ret_valid) begin
          rsp_word_d = bus_io.mem_ret_data;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (!bus_io.stall_icache) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state and stage 2; both hold naturally while stalled.
  always_comb begin
    bus_io.icache_busy       = busy;
    bus_io.icache_data_valid = s2_hit || (state_q == StResp);
    bus_io.icache_data       = (state_q == StResp) ? rsp_word_q : rd_data_q;
    bus_io.mem_rd_req        = 1'b0;
    bus_io.mem_rd_addr       = '0;
    bus_io.mem_rd_len        = '0;
    case (state_q)
      StMissReq: begin
        bus_io.mem_rd_req  = 1'b1;
        bus_io.mem_rd_addr = {pa_q[31:SetLsb], {SetLsb{1'b0}}};
        bus_io.mem_rd_len  = 8'(LINE_WORDS - 1);
      end
      StUncReq: begin
        bus_io.mem_rd_req  = 1'b1;
        bus_io.mem_rd_addr = {pa_q[31:2], 2'b00};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus random ops against a line-level cache model.
module tb_icache_ctrl;
  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpRead   = 3'd1;
  localparam logic [2:0] OpIdxInv = 3'd2;
  localparam logic [2:0] OpHitInv = 3'd3;

  logic clk;
  logic rst;

  icache_ctrl_if bus ();

  icache_ctrl #(
    .LINE_WORDS(4),
    .SETS      (256),
    .TAG_W     (20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          req_cnt = 0;
  int          abort_beats = -1;
  int          abort_cnt = 0;
  logic [31:0] req_addr, req_first_addr;
  logic [7:0]  req_len, req_first_len;

  logic [31:0] preload [logic [31:0]];
  logic        m_valid [256];
  logic [19:0] m_tag   [256];
  logic [31:0] m_data  [256][4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (preload.exists(a)) return preload[a];
    return a ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // Memory bridge: accepts a request after a random delay, returns beats with random gaps.
  initial begin
    bus.mem_rd_rdy    = 1'b0;
    bus.mem_ret_valid = 1'b0;
    bus.mem_ret_last  = 1'b0;
    bus.mem_ret_data  = '0;
    forever begin
      step();
      if (!rst && bus.mem_rd_req) begin
        req_first_addr = bus.mem_rd_addr;
        req_first_len  = bus.mem_rd_len;
        repeat ($urandom_range(0, 2)) step();
        req_addr = bus.mem_rd_addr;
        req_len  = bus.mem_rd_len;
        req_cnt++;
        bus.mem_rd_rdy = 1'b1;
        step();
        bus.mem_rd_rdy = 1'b0;
        for (int b = 0; b <= int'(req_len); b++) begin
          if (b == abort_beats) begin
            abort_cnt++;
            break;
          end
          if ($urandom_range(0, 3) == 0) step();
          bus.mem_ret_valid = 1'b1;
          bus.mem_ret_data  = mem_word(req_addr + 32'(4 * b));
          bus.mem_ret_last  = (b == int'(req_len));
          step();
          bus.mem_ret_valid = 1'b0;
          bus.mem_ret_last  = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.icache_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_eq("ready", 32'(bus.icache_busy), 32'd0);
  endtask

  // Hold a response under s stall cycles while offering a decoy request that must not be taken.
  task automatic hold_rsp(input int s, input logic [31:0] exp, input string tag);
    for (int i = 0; i <= s; i++) begin
      check_eq({tag, "_dv"}, 32'(bus.icache_data_valid), 32'd1);
      check_eq({tag, "_data"}, bus.icache_data, exp);
      if (i == s) break;
      bus.icache_op        = OpRead;
      bus.icache_idx       = 12'($urandom);
      bus.icache_pa        = $urandom;
      bus.icache_is_cached = 1'b1;
      step();
      if (i + 1 == s) begin
        bus.stall_icache = 1'b0;
        bus.icache_op    = OpNop;
      end
    end
    step();
    check_eq({tag, "_dv_drop"}, 32'(bus.icache_data_valid), 32'd0);
    check_eq({tag, "_busy_drop"}, 32'(bus.icache_busy), 32'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [11:0] idx, input logic [31:0] pa,
                       input logic cached, input int s);
    logic [7:0]  si;
    logic [1:0]  w;
    logic [31:0] exp, eaddr, line;
    logic [7:0]  elen;
    int          kind, req0, n;
    si = idx[11:4];
    w  = idx[3:2];
    exp = '0; eaddr = '0; elen = '0;
    wait_ready();
    bus.icache_op        = op;
    bus.icache_idx       = idx;
    bus.icache_pa        = pa;
    bus.icache_is_cached = cached;
    req0 = req_cnt;
    step();
    bus.icache_op = OpNop;
    kind = 0;
    if (op == OpIdxInv) begin
      kind = 1;
      m_valid[si] = 1'b0;
    end else if (op == OpHitInv) begin
      kind = 1;
      if (m_valid[si] && m_tag[si] == pa[31:12]) m_valid[si] = 1'b0;
    end else if (op == OpRead) begin
      if (cached && m_valid[si] && m_tag[si] == pa[31:12]) begin
        kind = 2;
        exp  = m_data[si][w];
      end else if (cached) begin
        kind  = 3;
        line  = {pa[31:4], 4'h0};
        for (int i = 0; i < 4; i++) m_data[si][i] = mem_word(line + 32'(4 * i));
        m_valid[si] = 1'b1;
        m_tag[si]   = pa[31:12];
        exp   = m_data[si][w];
        eaddr = line;
        elen  = 8'd3;
      end else begin
        kind  = 3;
        eaddr = {pa[31:2], 2'b00};
        elen  = 8'd0;
        exp   = mem_word(eaddr);
      end
    end
    if (kind < 2) begin
      check_eq("noread_dv", 32'(bus.icache_data_valid), 32'd0);
      check_eq("noread_busy", 32'(bus.icache_busy), 32'd0);
      step();
      check_eq("noread_mem", 32'(req_cnt), 32'(req0));
      return;
    end
    bus.stall_icache = (s > 0);
    if (kind == 2) begin
      check_eq("hit_busy", 32'(bus.icache_busy), 32'd0);
      check_eq("hit_no_req", 32'(bus.mem_rd_req), 32'd0);
      hold_rsp(s, exp, "hit");
      check_eq("hit_mem", 32'(req_cnt), 32'(req0));
    end else begin
      check_eq("miss_busy", 32'(bus.icache_busy), 32'd1);
      check_eq("miss_dv", 32'(bus.icache_data_valid), 32'd0);
      n = 0;
      while (bus.icache_data_valid !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      check_eq("fill_rsp_seen", 32'(bus.icache_data_valid), 32'd1);
      if (bus.icache_data_valid === 1'b1) hold_rsp(s, exp, "fill");
      bus.stall_icache = 1'b0;
      check_eq("fill_req_cnt", 32'(req_cnt), 32'(req0 + 1));
      check_eq("fill_addr", req_addr, eaddr);
      check_eq("fill_len", 32'(req_len), 32'(elen));
      check_eq("fill_addr_stable", req_first_addr, eaddr);
      check_eq("fill_len_stable", 32'(req_first_len), 32'(elen));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_data"}, bus.icache_data, 32'd0);
    check_eq({tag, "_dv"}, 32'(bus.icache_data_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.icache_busy), 32'd0);
    check_eq({tag, "_req"}, 32'(bus.mem_rd_req), 32'd0);
    check_eq({tag, "_addr"}, bus.mem_rd_addr, 32'd0);
    check_eq({tag, "_len"}, 32'(bus.mem_rd_len), 32'd0);
  endtask

  initial begin
    logic [19:0] tg;
    logic [31:0] pa;
    logic [11:0] idx;
    logic [2:0]  op;
    int          r, s, ac0, n;
    rst                  = 1'b1;
    bus.stall_icache     = 1'b0;
    bus.icache_op        = OpNop;
    bus.icache_idx       = '0;
    bus.icache_pa        = '0;
    bus.icache_is_cached = 1'b0;
    preload[32'h1C00_0000] = 32'h0000_00A0;
    preload[32'h1C00_0004] = 32'h0000_00A1;
    preload[32'h1C00_0008] = 32'h0000_00A2;
    preload[32'h1C00_000C] = 32'h0000_00A3;
    preload[32'h1FE0_0010] = 32'h1234_5678;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    step();
    step();
    check_reset_outs("reset");
    rst = 1'b0;
    step();

    // Cold miss, then hit on the same line
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b1, 0);
    do_op(OpRead, 12'h008, 32'h1C00_0008, 1'b1, 0);
    // Uncached to a cached set, and with a matching tag; line must stay intact
    do_op(OpRead, 12'h004, 32'h1FE0_0010, 1'b0, 0);
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b0, 1);
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b1, 0);
    // Hit held under a 3-cycle stall
    do_op(OpRead, 12'h008, 32'h1C00_0008, 1'b1, 3);

    // Back-to-back hits: stage 2 of the first overlaps accept of the second
    wait_ready();
    bus.icache_op        = OpRead;
    bus.icache_idx       = 12'h004;
    bus.icache_pa        = 32'h1C00_0004;
    bus.icache_is_cached = 1'b1;
    step();
    bus.icache_idx = 12'h00C;
    bus.icache_pa  = 32'h1C00_000C;
    check_eq("pipe0_dv", 32'(bus.icache_data_valid), 32'd1);
    check_eq("pipe0_data", bus.icache_data, 32'h0000_00A1);
    check_eq("pipe0_busy", 32'(bus.icache_busy), 32'd0);
    step();
    bus.icache_op = OpNop;
    check_eq("pipe1_dv", 32'(bus.icache_data_valid), 32'd1);
    check_eq("pipe1_data", bus.icache_data, 32'h0000_00A3);
    step();
    check_eq("pipe2_dv", 32'(bus.icache_data_valid), 32'd0);

    // Invalidates
    do_op(OpIdxInv, 12'h004, 32'h0, 1'b1, 0);
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b1, 0);
    do_op(OpHitInv, 12'h004, 32'h2C00_0004, 1'b1, 0);
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b1, 0);
    do_op(OpHitInv, 12'h004, 32'h1C00_0004, 1'b1, 0);
    do_op(OpRead, 12'h00C, 32'h1C00_000C, 1'b1, 2);
    do_op(3'd5, 12'h004, 32'h1C00_0004, 1'b1, 0);

    // Random traffic over a few sets and tags
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 3));
      tg = (r == 0) ? 20'h1C000 : (r == 1) ? 20'h2C000 : (r == 2) ? 20'h1C001 : 20'h3F00A;
      pa = {tg, 4'h0, 4'($urandom_range(0, 7)), 2'($urandom), 2'b00};
      idx = pa[11:0];
      if ($urandom_range(0, 99) < 15) idx = {4'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
      r = int'($urandom_range(0, 99));
      op = (r < 70) ? OpRead : (r < 80) ? OpIdxInv : (r < 92) ? OpHitInv :
           (r < 96) ? 3'($urandom_range(4, 7)) : OpNop;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(op, idx, pa, ($urandom_range(0, 99) < 85), s);
    end

    // Reset in the middle of a refill, after two beats
    do_op(OpIdxInv, 12'h004, 32'h0, 1'b1, 0);
    abort_beats = 2;
    ac0 = abort_cnt;
    wait_ready();
    bus.icache_op        = OpRead;
    bus.icache_idx       = 12'h004;
    bus.icache_pa        = 32'h1C00_0004;
    bus.icache_is_cached = 1'b1;
    step();
    bus.icache_op = OpNop;
    n = 0;
    while (abort_cnt == ac0 && n < 100) begin
      step();
      n++;
    end
    check_eq("abort_seen", 32'(abort_cnt), 32'(ac0 + 1));
    rst = 1'b1;
    #1;
    check_reset_outs("midfill_rst");
    step();
    rst = 1'b0;
    abort_beats = -1;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    step();
    do_op(OpRead, 12'h004, 32'h1C00_0004, 1'b1, 0);
    do_op(OpRead, 12'h008, 32'h1C00_0008, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end
endmodule
